gf16_inv_arbiter: RTL and testbench

Shares one combinational GF(2^4) tower-field inverter (the `Canright` block) among N_REQ requesters, such as the S-box lanes of the byte-serial AES datapath. Round-robin arbitration grants one request per cycle into a fixed-latency pipeline. Each response is returned tagged with the requester index. A `hold` input freezes the whole block, for example while the DOM randomness source refills.

---
 rtl/gf16_pkg.sv | 37 +++
 rtl/gf16_inv_arbiter_if.sv | 29 ++
 rtl/gf16_inv_core.sv | 48 ++++
 rtl/gf16_inv_arbiter.sv | 92 +++++++++
 tb/tb_gf16_inv_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/gf16_pkg.sv
// Shared types and helpers for the GF(2^4) inverter arbiter.
// Widths are sized for the largest legal requester count (8).
package gf16_pkg;

  localparam int GF16_W    = 4;
  localparam int N_REQ_MAX = 8;
  localparam int ID_MAX_W  = 3;

  typedef struct packed {
    logic                vld;
    logic [ID_MAX_W-1:0] id;
    logic [GF16_W-1:0]   dat;
  } gf16_entry_t;

  typedef struct packed {
    logic                hit;
    logic [ID_MAX_W-1:0] idx;
  } rr_pick_t;

  // Unused requester bits must be zero: searching modulo 8 then visits the
  // populated bits in the same order as searching modulo N_REQ.
  function automatic rr_pick_t rr_pick(input logic [N_REQ_MAX-1:0] valid,
                                       input logic [ID_MAX_W-1:0]  last);
    rr_pick_t            res;
    logic [ID_MAX_W-1:0] cand;
    res = '0;
    for (int k = N_REQ_MAX; k >= 1; k--) begin
      cand = last + ID_MAX_W'(k);
      if (valid[cand]) begin
        res.hit = 1'b1;
        res.idx = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gf16_inv_arbiter_if.sv
// Request/response bundle between N_REQ requesters and the shared inverter.
// master = requester side, slave = arbiter side.
interface gf16_inv_arbiter_if
  import gf16_pkg::*;
#(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic                      hold;
  logic [N_REQ-1:0]          req_valid;
  logic [GF16_W*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ-1:0]          rsp_valid;
  logic [GF16_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;
  logic                      busy;

  modport master (
    output hold, req_valid, req_data,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  hold, req_valid, req_data,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

endinterface

// File: rtl/gf16_inv_core.sv
// Combinational GF(2^4) inverse (0 -> 0) in the x^4+x+1 polynomial basis,
// computed through the tower GF((2^2)^2) with Y^2+Y+w over GF(4)=GF(2)[w]/(w^2+w+1).
module gf16_inv_core
  import gf16_pkg::*;
(
  input  logic [GF16_W-1:0] x_i,
  output logic [GF16_W-1:0] y_o
);

  // Row i (bits [4i+3:4i]) is the parity mask for output bit i; x maps to Y.
  localparam logic [15:0] TO_TOWER   = {4'b1000, 4'b1110, 4'b1100, 4'b0001};
  localparam logic [15:0] FROM_TOWER = {4'b1000, 4'b1010, 4'b0110, 4'b0001};

  function automatic logic [3:0] mat4(input logic [15:0] m, input logic [3:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ^(m[4*i +: 4] & v);
    return r;
  endfunction

  function automatic logic [1:0] gf4_mul(input logic [1:0] p, input logic [1:0] q);
    return {(p[1] & q[1]) ^ (p[1] & q[0]) ^ (p[0] & q[1]),
            (p[1] & q[1]) ^ (p[0] & q[0])};
  endfunction

  function automatic logic [1:0] gf4_sq(input logic [1:0] p);
    return {p[1], p[1] ^ p[0]};
  endfunction

  function automatic logic [1:0] gf4_mul_lam(input logic [1:0] p);
    return {p[1] ^ p[0], p[1]};
  endfunction

  logic [3:0] tw;
  logic [1:0] hi, lo, delta, dinv, inv_hi, inv_lo;

  always_comb begin
    tw     = mat4(TO_TOWER, x_i);
    hi     = tw[3:2];
    lo     = tw[1:0];
    delta  = gf4_mul_lam(gf4_sq(hi)) ^ gf4_mul(hi, lo) ^ gf4_sq(lo);
    // In GF(4) the inverse is the square, and 0 stays 0.
    dinv   = gf4_sq(delta);
    inv_hi = gf4_mul(hi, dinv);
    inv_lo = gf4_mul(hi ^ lo, dinv);
    y_o    = mat4(FROM_TOWER, {inv_hi, inv_lo});
  end

endmodule

// File: rtl/gf16_inv_arbiter.sv
// Round-robin arbiter feeding one shared GF(2^4) inverter through a LAT-cycle
// pipeline; responses carry the requester id, hold freezes everything.
module gf16_inv_arbiter
  import gf16_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT   = 2
)(
  input  logic               clk,
  input  logic               rst,
  gf16_inv_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]   last_q, last_d;
  rr_pick_t          pick;
  logic [N_REQ-1:0]  grant;
  logic [GF16_W-1:0] op_dat;
  logic              hs;
  gf16_entry_t       pipe_q [LAT];
  gf16_entry_t       pipe_d [LAT];
  gf16_entry_t       fin;
  logic [GF16_W-1:0] inv_dat;
  logic [N_REQ-1:0]  rsp_vld;
  logic              busy;

  always_comb begin
    pick   = rr_pick(N_REQ_MAX'(bus.req_valid), ID_MAX_W'(last_q));
    grant  = '0;
    op_dat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!bus.hold && pick.hit && pick.idx == ID_MAX_W'(i)) begin
        grant[i] = 1'b1;
        op_dat   = bus.req_data[GF16_W*i +: GF16_W];
      end
    end
    hs     = |grant;
    last_d = hs ? pick.idx[ID_W-1:0] : last_q;
  end

  assign bus.req_ready = grant;

  gf16_inv_core u_inv (
    .x_i (pipe_q[0].dat),
    .y_o (inv_dat)
  );

  // Stage 0 holds the operand; every later stage holds the inverse.
  always_comb begin
    pipe_d[0]     = '0;
    pipe_d[0].vld = hs;
    if (hs) begin
      pipe_d[0].id  = pick.idx;
      pipe_d[0].dat = op_dat;
    end
    for (int k = 1; k < LAT; k++) begin
      pipe_d[k] = pipe_q[k-1];
      if (k == 1) pipe_d[k].dat = inv_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= ID_W'(N_REQ - 1);
      for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
    end else if (!bus.hold) begin
      last_q <= last_d;
      for (int k = 0; k < LAT; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  always_comb begin
    fin = pipe_q[LAT-1];
    if (LAT == 1) fin.dat = inv_dat;
  end

  always_comb begin
    rsp_vld = '0;
    busy    = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      rsp_vld[i] = fin.vld && !bus.hold && fin.id == ID_MAX_W'(i);
    for (int k = 0; k < LAT; k++)
      busy = busy | pipe_q[k].vld;
  end

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_data  = fin.dat;
  assign bus.rsp_id    = fin.id[ID_W-1:0];
  assign bus.busy      = busy;

endmodule

// File: tb/tb_gf16_inv_arbiter.sv
// Scoreboard bench for gf16_inv_arbiter (N_REQ=4, LAT=2) against a
// polynomial-basis GF(2^4) golden model and a round-robin grant model.
module tb_gf16_inv_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gf16_inv_arbiter_if #(.N_REQ(N)) bus ();

  gf16_inv_arbiter #(.N_REQ(N), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         id;
    logic [3:0] dat;
    int         due;
  } sb_t;

  sb_t sbq [$];
  int  g_id [$];
  int  g_cyc [$];
  int  n_chk = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  act = 0;
  int  last_m = N - 1;
  logic [3:0] mon_er, mon_ev;
  int  mon_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r, aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'b0011 : 4'b0000);
    end
    return r;
  endfunction

  function automatic logic [3:0] ginv(input logic [3:0] x);
    logic [3:0] r;
    r = '0;
    for (int c = 1; c < 16; c++)
      if (gmul(x, 4'(c)) == 4'h1) r = 4'(c);
    return r;
  endfunction

  function automatic logic [3:0] exp_ready(input logic [3:0] v, input int last, input logic h);
    logic [3:0] r;
    bit         found;
    r     = '0;
    found = 0;
    if (!h) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (last + k) % N;
        if (!found && v[i]) begin
          r[i]  = 1'b1;
          found = 1;
        end
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sbq.delete();
      last_m = N - 1;
    end else begin
      chk("busy", 32'(bus.busy), 32'(sbq.size() != 0));
      mon_er = exp_ready(bus.req_valid, last_m, bus.hold);
      chk("req_ready", 32'(bus.req_ready), 32'(mon_er));
      mon_ev = '0;
      if (!bus.hold && sbq.size() != 0 && sbq[0].due == act) mon_ev = 4'b0001 << sbq[0].id;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(mon_ev));
      if (mon_ev != 0) begin
        chk("rsp_id", 32'(bus.rsp_id), sbq[0].id);
        chk("rsp_data", 32'(bus.rsp_data), 32'(sbq[0].dat));
        void'(sbq.pop_front());
      end
      if (mon_er != 0) begin
        mon_idx = 0;
        for (int i = 0; i < N; i++) if (mon_er[i]) mon_idx = i;
        sbq.push_back('{id: mon_idx, dat: ginv(bus.req_data[4*mon_idx +: 4]), due: act + LAT});
        last_m = mon_idx;
        g_id.push_back(mon_idx);
        g_cyc.push_back(cyc);
      end
      if (!bus.hold) act++;
    end
  end

  task automatic drain();
    for (int n = 0; n < 20 && (sbq.size() != 0 || bus.busy); n++) @(posedge clk);
    #1;
    chk("drain", 32'(sbq.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    @(posedge clk) #1 rst = 1'b0;

    // single request from requester 2
    @(posedge clk) #1;
    bus.req_valid = 4'b0100;
    bus.req_data  = 16'h0100;
    #1 chk("single_ready", 32'(bus.req_ready), 32'h4);
    @(posedge clk) #1 bus.req_valid = '0;
    drain();

    // all 16 operands back-to-back from requester 0
    for (int x = 0; x < 16; x++) begin
      @(posedge clk) #1;
      bus.req_valid = 4'b0001;
      bus.req_data  = 16'(x);
    end
    @(posedge clk) #1 bus.req_valid = '0;
    drain();

    // round-robin from reset pointer
    @(posedge clk) #1 rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    g_id.delete();
    g_cyc.delete();
    bus.req_valid = 4'b1111;
    bus.req_data  = 16'h9C3E;
    repeat (8) @(posedge clk);
    #1 bus.req_valid = '0;
    chk("rr_count", 32'(g_id.size()), 8);
    for (int i = 0; i < 8; i++)
      if (i < g_id.size()) chk("rr_order", g_id[i], i % N);
    drain();

    // hold with two entries in flight and requests pending
    @(posedge clk) #1;
    bus.req_valid = 4'b0001;
    bus.req_data  = 16'h0005;
    @(posedge clk) #1 bus.req_data = 16'h0006;
    @(posedge clk) #1;
    bus.hold      = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data  = 16'hABCD;
    #1 chk("hold_ready", 32'(bus.req_ready), 0);
    chk("hold_rsp", 32'(bus.rsp_valid), 0);
    repeat (2) @(posedge clk);
    @(posedge clk) #1;
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    drain();

    // asynchronous reset with LAT entries in flight
    @(posedge clk) #1;
    bus.req_valid = 4'b0001;
    bus.req_data  = 16'h0007;
    @(posedge clk) #1 bus.req_data = 16'h0008;
    @(posedge clk) #1 bus.req_valid = '0;
    #1 chk("pre_rst_busy", 32'(bus.busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_busy", 32'(bus.busy), 0);
    chk("async_rsp_valid", 32'(bus.rsp_valid), 0);
    @(posedge clk) #1;
    rst           = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = 16'h2468;
    #1 chk("rst_first_grant", 32'(bus.req_ready), 32'h1);
    repeat (3) @(posedge clk);
    #1 bus.req_valid = '0;
    drain();

    // sparse: requester 3 then requester 1 on consecutive cycles
    g_id.delete();
    g_cyc.delete();
    @(posedge clk) #1;
    bus.req_valid = 4'b1000;
    bus.req_data  = 16'hF000;
    @(posedge clk) #1;
    bus.req_valid = 4'b0010;
    bus.req_data  = 16'h00B0;
    @(posedge clk) #1 bus.req_valid = '0;
    chk("sparse_n", 32'(g_id.size()), 2);
    if (g_id.size() >= 2) begin
      chk("sparse_first", g_id[0], 3);
      chk("sparse_second", g_id[1], 1);
      chk("sparse_gap", g_cyc[1] - g_cyc[0], 1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
